aes_shift_rows_stream: RTL
==========================

# aes_shift_rows_stream

Byte-serial ShiftRows engine for the encryption datapath, the forward counterpart of the inverse-ShiftRows stage used in decryption. It accepts a 128-bit AES state as 16 bytes over a valid/ready stream, buffers the block, and emits the row-shifted state byte-serially on a second valid/ready stream. Two ping-pong banks let one block fill while the previous block drains, so it sustains 1 byte/cycle between byte-serial SubBytes and MixColumns stages.

## Interface
- INV, default 0: 0 = forward ShiftRows (encrypt); 1 = inverse ShiftRows (decrypt reuse).
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all buffered and partial blocks.
- in_valid  input  1  in_data holds a valid byte.
- in_ready  output  1  engine accepts a byte this cycle.
- in_data  input  8  state byte, stream order k = 0..15.
- out_valid  output  1  out_data holds a valid shifted byte.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  8  shifted state byte, stream order k = 0..15.
- out_last  output  1  high with out_valid on output byte k = 15.

## Operation
- Byte order matches the 128-bit state convention: k = 4c + r, byte 0 = bits [127:120], column c, row r.
- Forward (INV=0): output byte 4c+r = input byte 4((c+r) mod 4)+r. Inverse (INV=1): output byte 4c+r = input byte 4((c−r) mod 4)+r.
- Storage: two 128-bit banks, each with a full flag. Write side holds wbank (1 bit) and wcnt (4 bits). Read side holds rbank (1 bit) and rcnt (4 bits).
- Per-bank cycle: EMPTY → FILLING (first write) → FULL (16th write) → DRAINING (first read) → EMPTY (16th read).
- Write handshake (in_valid & in_ready) stores in_data at byte wcnt of bank wbank and increments wcnt. On wcnt = 15 it sets full[wbank], toggles wbank, and wraps wcnt to 0.
- in_ready = !full[wbank].
- out_valid = full[rbank]. out_data = the mapped byte for rcnt from bank rbank, and 8'h00 when out_valid = 0. out_last = out_valid & (rcnt == 15).
- Read handshake (out_valid & out_ready) increments rcnt. On rcnt = 15 it clears full[rbank], toggles rbank, and wraps rcnt to 0.
- Simultaneous fill-complete on one bank and drain-complete on the other in the same cycle are both honoured. The same bank is never written and read in the same cycle.
- flush clears full flags, wbank, rbank, wcnt, and rcnt. It overrides any handshake in the same cycle, and the data presented in that cycle is discarded.
- Bank data registers need not be reset.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_data = 8'h00, out_last = 0; all pointers and counters 0; both banks EMPTY.
- Latency: the 16th input handshake in cycle N gives out_valid = 1 in cycle N+1. Minimum latency from first input byte to first output byte is 16 cycles.
- Throughput: with in_valid and out_ready held high, 1 byte/cycle in and 1 byte/cycle out, with no bubbles across block boundaries.
- Stall rules:
  - Both banks full: in_ready = 0 until a drain completes, then in_ready = 1 on the cycle after the 16th read.
  - out_ready = 0: out_data and out_last stay stable while out_valid = 1.
  - in_valid = 0 mid-block: wcnt holds; there is no timeout.
- Flush or reset mid-block: the partial input block is lost and any draining block is truncated. The cycle after flush shows out_valid = 0 and in_ready = 1.
- Asynchronous reset takes effect immediately, regardless of clk.

## Test plan
- INV=0, input 00..0F, out_ready = 1 → output 00 05 0A 0F 04 09 0E 03 08 0D 02 07 0C 01 06 0B; out_last only on 0B; first out_valid one cycle after the 16th input.
- INV=1, input 00..0F → output 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03.
- Back-to-back blocks 00..0F then 10..1F, all valid/ready high → 32 consecutive output bytes with no gap; second block is 10 15 1A 1F ...
- out_ready = 0 for 40 cycles while feeding 3 blocks → in_ready drops after byte 31 (both banks full). Output holds 00 with out_valid = 1. After release, the full 32-byte sequence is correct, and block 3 resumes on the cycle after the 16th read.
- Random in_valid and out_ready gaps (≈30 % idle) over 100 random blocks → output matches the software ShiftRows model byte-for-byte.
- flush after 7 input bytes, and separately rst_n low mid-drain → the next cycle shows out_valid = 0 and in_ready = 1; the following block 00..0F produces exactly the first-scenario sequence.

Source files
------------

// File: rtl/aes_shift_rows_stream.sv
// Byte-serial AES ShiftRows (or InvShiftRows when INV=1) engine with two ping-pong
// 16-byte banks so one block fills while the previous block drains.
module aes_shift_rows_stream #(
  parameter bit INV = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last
);

  logic [7:0] bank_q [2][16];
  logic [1:0] full_q, full_d;
  logic       wbank_q, wbank_d;
  logic       rbank_q, rbank_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [3:0] rcnt_q, rcnt_d;

  logic       wr_fire;
  logic       rd_fire;
  logic [1:0] src_col;
  logic [3:0] src_idx;

  assign in_ready  = !full_q[wbank_q];
  assign out_valid = full_q[rbank_q];
  // flush wins over both handshakes; the byte presented alongside it is dropped.
  assign wr_fire   = in_valid & in_ready & !flush;
  assign rd_fire   = out_valid & out_ready & !flush;

  // Stream index k = 4c + r; the source column wraps mod 4 via 2-bit arithmetic.
  always_comb begin
    if (INV) src_col = rcnt_q[3:2] - rcnt_q[1:0];
    else     src_col = rcnt_q[3:2] + rcnt_q[1:0];
    src_idx  = {src_col, rcnt_q[1:0]};
    out_data = out_valid ? bank_q[rbank_q][src_idx] : 8'h00;
    out_last = out_valid & (rcnt_q == 4'd15);
  end

  // The writer only touches a non-full bank and the reader only a full one, so a
  // fill-complete and a drain-complete in the same cycle always hit different banks.
  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    full_d  = full_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    if (flush) begin
      full_d  = 2'b00;
      wbank_d = 1'b0;
      rbank_d = 1'b0;
      wcnt_d  = 4'd0;
      rcnt_d  = 4'd0;
    end else begin
      if (wr_fire) begin
        wcnt_d = wcnt_q + 4'd1;
        if (wcnt_q == 4'd15) begin
          full_d[wbank_q] = 1'b1;
          wbank_d         = ~wbank_q;
        end
      end
      if (rd_fire) begin
        rcnt_d = rcnt_q + 4'd1;
        if (rcnt_q == 4'd15) begin
          full_d[rbank_q] = 1'b0;
          rbank_d         = ~rbank_q;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 2'b00;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      wcnt_q  <= 4'd0;
      rcnt_q  <= 4'd0;
    end else begin
      full_q  <= full_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // NOTE: bank storage is deliberately not reset; the full flags decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_fire) bank_q[wbank_q][wcnt_q] <= in_data;
  end

endmodule
